mulu_int: RTL and testbench
===========================

Name: mulu_int

Overview:
- Sequential unsigned shift-add multiply-accumulate: computes prod = a*b + c, one partial-product bit per clock.
- Start/busy/done/valid control contract identical to the team's integer divider. The two can share a control wrapper.
- Serves as the inverse of the divider: feeding quotient, divisor and remainder reconstructs the dividend. Used in divider self-check and fixed-point scaling paths.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
clk    input   1          clock; all logic on rising edge
rstn   input   1          reset, synchronous, active-low
start  input   1          begin calculation; samples a, b, c
busy   output  1          calculation in progress
done   output  1          calculation complete; high for exactly one cycle
valid  output  1          prod/ovf hold a completed result
ovf    output  1          result does not fit in WIDTH bits (prod[2*WIDTH-1:WIDTH] != 0)
a      input   WIDTH      multiplicand
b      input   WIDTH      multiplier
c      input   WIDTH      addend
prod   output  2*WIDTH    result a*b + c

Behaviour:
- Reset: rstn is synchronous active-low on clk. When rstn=0 at an edge, it overrides everything: busy=0, done=0, valid=0, ovf=0, prod=0, iteration counter=0.
- Width rule: max result is (2^W-1)^2 + (2^W-1) = 2^2W - 2^W. It always fits in 2*WIDTH bits, so no truncation is possible.
- Datapath registers:
  - hi: WIDTH+1 bits, initialised to c.
  - lo: WIDTH bits, initialised to b.
  - mcand: WIDTH bits, holds a.
  - i: $clog2(WIDTH) bits, iteration counter.
- Step (combinational): if lo[0], hi_n = hi + mcand, else hi_n = hi. Then {hi_next, lo_next} = {hi_n, lo} >> 1.
  - Initialising hi with c adds c to the result exactly, since hi carries weight 2^W and is shifted right W times.
- start sampled at edge T (rstn=1):
  - Load mcand, hi, lo; set i=0, busy=1, valid=0.
  - start has priority over an ongoing operation. Restart abandons the current op silently, with no done for it.
- Iteration while busy and !start:
  - i < WIDTH-1: register hi/lo next values, i=i+1.
  - i == WIDTH-1: prod = {hi_next[WIDTH-1:0], lo_next}, ovf = |hi_next[WIDTH-1:0], busy=0, done=1, valid=1.
- Latency: fixed. busy is high for WIDTH cycles (edges T+1..T+WIDTH). done and valid rise after edge T+WIDTH. No early exit for a=0, b=0 or c=0.
- done defaults to 0 every cycle. It pulses for one cycle only.
- Idle (busy=0, start=0): all outputs hold. prod, ovf and valid stay stable until the next start or reset.
- start in the same cycle that done would assert: start wins. The completing result is discarded, done stays 0 and valid=0.
- Reset mid-operation: the op is abandoned, no done pulse. The next start begins cleanly.
- No error case exists: every input combination is legal.

Decomposition:
- No shared-package typedefs are required.
- Iteration-count width $clog2(WIDTH) is a local constant.
- The start/busy/done/valid control encoding is common with the divider. If a shared arith package exists, it holds that status bundle type.
- No sub-module: one always_comb step function plus one always_ff control/datapath process.

Test Plan (WIDTH=8):
- Basic: a=13, b=11, c=0 -> done exactly 8 cycles after start; prod=143, ovf=0, valid=1; busy high 8 cycles.
- Max operands: a=255, b=255, c=255 -> prod=65280 (0xFF00), ovf=1.
- Divider round-trip: 200/7 gives q=28, r=4. Drive a=28, b=7, c=4 -> prod=200, ovf=0.
- Zero multiplier: a=77, b=0, c=9 -> prod=9 after full 8-cycle latency, ovf=0.
- Restart: start a=3, b=4, c=0; re-start 3 cycles later with a=5, b=6, c=1 -> exactly one done, 8 cycles after the second start; prod=31.
- Reset mid-op: start a=10, b=10, c=0; rstn=0 at cycle 4 -> busy=0, valid=0, prod=0, no done. A new start afterwards gives the correct result.

Source files
------------

// File: rtl/mulu_int_pkg.sv
// Shared types for the sequential integer arithmetic units (multiplier, divider).
// Holds the control FSM encoding and the start/busy/done/valid status bundle.
package mulu_int_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arith_state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic valid;
    } arith_status_t;

endpackage

// File: rtl/mulu_int_if.sv
// Operand/result bundle for mulu_int; master issues start with a/b/c, slave returns status and prod/ovf.
interface mulu_int_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic               busy;
    logic               done;
    logic               valid;
    logic               ovf;
    logic [2*WIDTH-1:0] prod;

    modport master (
        output start, a, b, c,
        input  busy, done, valid, ovf, prod
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, valid, ovf, prod
    );
endinterface

// File: rtl/mulu_int.sv
// Sequential unsigned shift-add multiply-accumulate prod = a*b + c; latency WIDTH cycles after start.
// No backpressure: start is always accepted and restarts any op in flight; results hold until next start.
module mulu_int
    import mulu_int_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    mulu_int_if.slave  io
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    arith_state_e         state_q, state_d;
    logic [WIDTH:0]       hi_q, hi_d, hi_nx;
    logic [WIDTH-1:0]     lo_q, lo_d, lo_nx;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [IW-1:0]        i_q, i_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    arith_status_t        stat;

    // One partial-product bit: conditional add into the high half, then shift the pair right.
    // hi starts as c, so after WIDTH shifts c lands at weight 2^0 of the result.
    always_comb begin
        logic [WIDTH:0] hi_sum;
        hi_sum = lo_q[0] ? (hi_q + {1'b0, mcand_q}) : hi_q;
        {hi_nx, lo_nx} = {hi_sum, lo_q} >> 1;
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        i_d     = i_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (io.start) begin
            state_d = ST_BUSY;
            hi_d    = {1'b0, io.c};
            lo_d    = io.b;
            mcand_d = io.a;
            i_d     = '0;
            valid_d = 1'b0;
        end else if (state_q == ST_BUSY) begin
            if (i_q == LAST) begin
                state_d = ST_IDLE;
                prod_d  = {hi_nx[WIDTH-1:0], lo_nx};
                ovf_d   = |hi_nx[WIDTH-1:0];
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                hi_d = hi_nx;
                lo_d = lo_nx;
                i_d  = i_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            i_q     <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            i_q     <= i_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign stat.busy  = (state_q == ST_BUSY);
    assign stat.done  = done_q;
    assign stat.valid = valid_q;

    assign io.busy  = stat.busy;
    assign io.done  = stat.done;
    assign io.valid = stat.valid;
    assign io.ovf   = ovf_q;
    assign io.prod  = prod_q;

endmodule

// File: tb/tb_mulu_int.sv
// Scoreboarded directed bench for mulu_int (WIDTH=8): driver queues expected results, monitor checks on done.
module tb_mulu_int;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        logic           ovf;
        int             due;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;
    int   n_done;
    exp_t exp_q[$];

    mulu_int_if #(.WIDTH(W)) io();

    mulu_int #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge: start is sampled by the next rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [2*W-1:0] p, input logic o);
        exp_t e;
        io.start = 1'b1;
        io.a = a;
        io.b = b;
        io.c = c;
        e.prod = p;
        e.ovf  = o;
        e.due  = cyc + 1 + W;
        exp_q.push_back(e);
        @(negedge clk);
        io.start = 1'b0;
    endtask

    task automatic abandon();
        void'(exp_q.pop_back());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn && io.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: prod %0d with nothing outstanding (cycle %0d)", io.prod, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("prod", io.prod, e.prod);
                chk("ovf", io.ovf, e.ovf);
                chk("valid_at_done", io.valid, 1);
                chk("busy_at_done", io.busy, 0);
                chk("latency", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int exp_dones;
        checks = 0;
        errors = 0;
        n_done = 0;
        exp_dones = 0;
        rstn = 1'b0;
        io.start = 1'b0;
        io.a = '0;
        io.b = '0;
        io.c = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", io.busy, 0);
        chk("rst_done", io.done, 0);
        chk("rst_valid", io.valid, 0);
        chk("rst_ovf", io.ovf, 0);
        chk("rst_prod", io.prod, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic: busy exactly W cycles, valid low while running, result holds when idle.
        start_op(8'd13, 8'd11, 8'd0, 16'd143, 1'b0);
        exp_dones++;
        chk("valid_while_busy", io.valid, 0);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (io.done) break;
            if (io.busy) nb++;
            @(negedge clk);
        end
        chk("busy_cycles", nb, W);
        repeat (3) @(negedge clk);
        chk("hold_prod", io.prod, 143);
        chk("hold_valid", io.valid, 1);
        chk("hold_done", io.done, 0);

        start_op(8'd255, 8'd255, 8'd255, 16'hFF00, 1'b1);
        exp_dones++;
        drain();
        start_op(8'd28, 8'd7, 8'd4, 16'd200, 1'b0);
        exp_dones++;
        drain();
        start_op(8'd77, 8'd0, 8'd9, 16'd9, 1'b0);
        exp_dones++;
        drain();
        start_op(8'd15, 8'd17, 8'd0, 16'd255, 1'b0);
        exp_dones++;
        drain();
        start_op(8'd16, 8'd16, 8'd0, 16'd256, 1'b1);
        exp_dones++;
        drain();

        // Restart three cycles into an op.
        start_op(8'd3, 8'd4, 8'd0, 16'd12, 1'b0);
        repeat (2) @(negedge clk);
        abandon();
        start_op(8'd5, 8'd6, 8'd1, 16'd31, 1'b0);
        exp_dones++;
        drain();

        // Restart on the very edge the first op would complete.
        start_op(8'd2, 8'd3, 8'd0, 16'd6, 1'b0);
        repeat (7) @(negedge clk);
        abandon();
        start_op(8'd100, 8'd3, 8'd7, 16'd307, 1'b1);
        exp_dones++;
        drain();

        // Reset mid-operation.
        start_op(8'd10, 8'd10, 8'd0, 16'd100, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", io.busy, 0);
        chk("midrst_valid", io.valid, 0);
        chk("midrst_prod", io.prod, 0);
        rstn = 1'b1;
        @(negedge clk);
        start_op(8'd10, 8'd10, 8'd0, 16'd100, 1'b0);
        exp_dones++;
        drain();

        repeat (12) @(negedge clk);
        chk("done_count", n_done, exp_dones);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
